tmds_channel_decoder: RTL and testbench

Receive-side counterpart of the per-channel TMDS encoder. Takes raw 10-bit words from a channel deserializer (arbitrary bit phase) and finds the word boundary by hunting for TMDS control tokens. Once locked, it decodes each word back to 8-bit video data or a 2-bit control code with a data-enable flag. One instance per TMDS channel (red, green, blue) in the HDMI capture path, in the pixel clock domain.

---
 rtl/tmds_channel_decoder.sv | 251 +++++++++++++++++++++++++
 tb/tb_tmds_channel_decoder.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tmds_channel_decoder.sv
// tmds_channel_decoder
//   Receive side of one TMDS channel. Raw 10-bit words from the deserializer
//   arrive with an unknown bit phase. The decoder hunts for the word boundary
//   by looking for runs of control tokens. Once locked, it turns each word back
//   into 8-bit video data or a 2-bit control code, plus a data-enable flag.
//
//   Optional feature (compile-time macro TMDS_RX_ERRCNT_EN):
//     defined   -> err_count counts LOCKED->SEARCH transitions and saturates
//                  at 0xFFFF. Only rst clears it.
//     undefined -> err_count is tied to 0.
//
//   Parameters
//     LOCK_TOKENS  consecutive tokens at the current offset needed to lock
//     SLIP_WORDS   valid words without a qualifying token run before a slip
//                  (SEARCH) or a loss of lock (LOCKED); must exceed a line
//
//   Ports
//     clk          pixel clock, rising edge
//     rst          asynchronous active-high reset
//     din[9:0]     raw deserialized word, bit 0 earliest in time
//     din_valid    din carries a new word this cycle
//     vd[7:0]      decoded video data
//     cd[1:0]      decoded control code {C1,C0}
//     vde          1 = data period, 0 = control period
//     dout_valid   vd/cd/vde updated this cycle
//     locked       word alignment established
//     align_offset current bit offset 0..9
//     err_count    lock-loss counter
module tmds_channel_decoder #(
  parameter int LOCK_TOKENS = 8,
  parameter int SLIP_WORDS  = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  din,
  input  logic        din_valid,
  output logic [7:0]  vd,
  output logic [1:0]  cd,
  output logic        vde,
  output logic        dout_valid,
  output logic        locked,
  output logic [3:0]  align_offset,
  output logic [15:0] err_count
);

  localparam int TOK_W  = $clog2(LOCK_TOKENS + 1);
  localparam int MISS_W = $clog2(SLIP_WORDS);

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t              state, state_nxt;
  logic [TOK_W-1:0]    tok_cnt, tok_nxt;
  logic [MISS_W-1:0]   miss_cnt, miss_nxt;
  logic [3:0]          offset, offset_nxt;

  logic [9:0]          cur_p0, prev_p0;
  logic [9:0]          q_p1;
  logic [7:0]          vd_p2, vd_nxt;
  logic [1:0]          cd_p2, cd_nxt;
  logic                vde_p2, vde_nxt;
  logic                vld_p2;

  logic                tok_hit, run_done, at_limit;

  function automatic logic is_token(input logic [9:0] q);
    logic hit;
    case (q)
      10'b1101010100,
      10'b0010101011,
      10'b0101010100,
      10'b1010101011: hit = 1'b1;
      default:        hit = 1'b0;
    endcase
    return hit;
  endfunction

  function automatic logic [1:0] token_cd(input logic [9:0] q);
    logic [1:0] c;
    case (q)
      10'b0010101011: c = 2'b01;
      10'b0101010100: c = 2'b10;
      10'b1010101011: c = 2'b11;
      default:        c = 2'b00;
    endcase
    return c;
  endfunction

  // Undo the optional inversion, then undo the XOR/XNOR transition chain
  // (q[8]=1 marks the XOR branch).
  function automatic logic [7:0] decode_data(input logic [9:0] q);
    logic [7:0] t;
    logic [7:0] v;
    t    = q[9] ? ~q[7:0] : q[7:0];
    v[0] = t[0];
    for (int i = 1; i < 8; i++) begin
      v[i] = q[8] ? (t[i] ^ t[i-1]) : ~(t[i] ^ t[i-1]);
    end
    return v;
  endfunction

  // w[19:10] is the newer word, so bit 0 of the window is earliest in time.
  function automatic logic [9:0] extract(input logic [19:0] w, input logic [3:0] k);
    logic [19:0] s;
    s = w >> k;
    return s[9:0];
  endfunction

  function automatic logic [3:0] next_offset(input logic [3:0] k);
    return (k == 4'd9) ? 4'd0 : k + 4'd1;
  endfunction

  always_comb begin
    state_nxt  = state;
    tok_nxt    = tok_cnt;
    miss_nxt   = miss_cnt;
    offset_nxt = offset;
    vd_nxt     = vd_p2;
    cd_nxt     = cd_p2;
    vde_nxt    = vde_p2;
    tok_hit    = is_token(q_p1);
    run_done   = 1'b0;
    at_limit   = (miss_cnt == MISS_W'(SLIP_WORDS - 1));
    if (din_valid) begin
      if (!tok_hit) begin
        tok_nxt = '0;
      end else if (tok_cnt != TOK_W'(LOCK_TOKENS)) begin
        tok_nxt = tok_cnt + TOK_W'(1);
      end
      run_done = tok_hit && (tok_nxt == TOK_W'(LOCK_TOKENS));

      // Lock/refresh is checked first so it wins over slip or loss.
      case (state)
        SEARCH: begin
          if (run_done) begin
            state_nxt = LOCKED;
            miss_nxt  = '0;
          end else if (at_limit) begin
            offset_nxt = next_offset(offset);
            tok_nxt    = '0;
            miss_nxt   = '0;
          end else begin
            miss_nxt = miss_cnt + MISS_W'(1);
          end
        end
        LOCKED: begin
          if (run_done) begin
            miss_nxt = '0;
          end else if (at_limit) begin
            state_nxt = SEARCH;
            tok_nxt   = '0;
            miss_nxt  = '0;
          end else begin
            miss_nxt = miss_cnt + MISS_W'(1);
          end
        end
        default: state_nxt = SEARCH;
      endcase

      // The output follows the state being entered, so locked and the
      // decoded word that completes the lock appear on the same edge.
      if (state_nxt == LOCKED) begin
        if (tok_hit) begin
          vde_nxt = 1'b0;
          cd_nxt  = token_cd(q_p1);
        end else begin
          vde_nxt = 1'b1;
          vd_nxt  = decode_data(q_p1);
        end
      end else begin
        vd_nxt  = '0;
        cd_nxt  = '0;
        vde_nxt = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= SEARCH;
      tok_cnt  <= '0;
      miss_cnt <= '0;
      offset   <= '0;
    end else begin
      state    <= state_nxt;
      tok_cnt  <= tok_nxt;
      miss_cnt <= miss_nxt;
      offset   <= offset_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_p0  <= '0;
      prev_p0 <= '0;
      q_p1    <= '0;
      vd_p2   <= '0;
      cd_p2   <= '0;
      vde_p2  <= 1'b0;
      vld_p2  <= 1'b0;
    end else begin
      // stage p0: capture the two-word window
      if (din_valid) begin
        cur_p0  <= din;
        prev_p0 <= cur_p0;
      end
      // stage p1: extract the aligned word at the current offset
      if (din_valid) begin
        q_p1 <= extract({cur_p0, prev_p0}, offset);
      end
      // stage p2: decoded outputs
      vd_p2  <= vd_nxt;
      cd_p2  <= cd_nxt;
      vde_p2 <= vde_nxt;
      vld_p2 <= din_valid;
    end
  end

`ifdef TMDS_RX_ERRCNT_EN
  logic [15:0] err_q;
  logic        lost;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign lost = (state == LOCKED) && (state_nxt == SEARCH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= '0;
    end else if (lost) begin
      err_q <= sat_inc16(err_q);
    end
  end

  assign err_count = err_q;
`else
  assign err_count = 16'd0;
`endif

  assign vd           = vd_p2;
  assign cd           = cd_p2;
  assign vde          = vde_p2;
  assign dout_valid   = vld_p2;
  assign locked       = (state == LOCKED);
  assign align_offset = offset;

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Testbench for tmds_channel_decoder: directed sequence with randomized data,
// checked every cycle against a behavioural model of the receive channel.
module tb_tmds_channel_decoder;

  localparam int LOCK_TOKENS = 8;
  localparam int SLIP_WORDS  = 1024;
`ifdef TMDS_RX_ERRCNT_EN
  localparam bit ERRCNT = 1'b1;
`else
  localparam bit ERRCNT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  din;
  logic        din_valid;
  logic [7:0]  vd;
  logic [1:0]  cd;
  logic        vde;
  logic        dout_valid;
  logic        locked;
  logic [3:0]  align_offset;
  logic [15:0] err_count;

  tmds_channel_decoder #(
    .LOCK_TOKENS(LOCK_TOKENS),
    .SLIP_WORDS (SLIP_WORDS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .din_valid   (din_valid),
    .vd          (vd),
    .cd          (cd),
    .vde         (vde),
    .dout_valid  (dout_valid),
    .locked      (locked),
    .align_offset(align_offset),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model state: received word history, pending aligned word, and receiver status.
  logic [9:0] m_p1, m_p2, m_pend;
  bit         m_locked;
  int         m_off, m_run, m_miss, m_err;
  logic [7:0] m_vd;
  logic [1:0] m_cd;
  logic       m_vde;

  int         vedge;
  logic [9:0] dw [14];
  logic [7:0] db [14];
  bit         dd [14];
  logic [7:0] blist [4];
  int         fall;
  logic [1:0] prev_cd;

  function automatic logic [9:0] tok_word(input int i);
    logic [9:0] w;
    case (i)
      0:       w = 10'b1101010100;
      1:       w = 10'b0010101011;
      2:       w = 10'b0101010100;
      default: w = 10'b1010101011;
    endcase
    return w;
  endfunction

  // Transition-minimising stage of the TMDS encoder.
  function automatic logic [7:0] tm_stage(input logic [7:0] d, input logic use_xnor);
    logic [7:0] m;
    m[0] = d[0];
    for (int i = 1; i < 8; i++) m[i] = use_xnor ? ~(m[i-1] ^ d[i]) : (m[i-1] ^ d[i]);
    return m;
  endfunction

  // Encoder word for byte d with the inversion bit forced to inv.
  function automatic logic [9:0] enc_word(input logic [7:0] d, input logic inv);
    int         n1;
    logic       xn;
    logic [7:0] m;
    n1 = $countones(d);
    xn = (n1 > 4) || (n1 == 4 && !d[0]);
    m  = tm_stage(d, xn);
    return {inv, ~xn, inv ? ~m : m};
  endfunction

  // Reference decode: find the byte whose encoding produces this word.
  function automatic logic [7:0] ref_decode(input logic [9:0] q);
    logic [7:0] t;
    logic [7:0] r;
    t = q[9] ? ~q[7:0] : q[7:0];
    r = 8'h00;
    for (int b = 0; b < 256; b++) begin
      if (tm_stage(8'(b), ~q[8]) == t) r = 8'(b);
    end
    return r;
  endfunction

  // The aligned word is ten consecutive serial bits starting k bits into the
  // two most recent words (older word first in time).
  function automatic logic [9:0] ref_slice(input logic [9:0] newer, input logic [9:0] older, input int k);
    logic [9:0] q;
    int idx;
    for (int j = 0; j < 10; j++) begin
      idx  = k + j;
      q[j] = (idx < 10) ? older[idx] : newer[idx-10];
    end
    return q;
  endfunction

  // Serial stream of cycling tokens delayed by 3 bits; word n >= 1.
  function automatic logic [9:0] stream_word(input int n);
    logic [9:0] w;
    logic [9:0] tk;
    int p;
    int ti;
    int tb;
    for (int b = 0; b < 10; b++) begin
      p = 10 * (n - 1) + b - 3;
      if (p < 0) begin
        ti = 3;
        tb = p + 10;
      end else begin
        ti = (p / 10) % 4;
        tb = p % 10;
      end
      tk   = tok_word(ti);
      w[b] = tk[tb];
    end
    return w;
  endfunction

  task automatic model_reset();
    m_p1 = '0; m_p2 = '0; m_pend = '0;
    m_locked = 1'b0; m_off = 0; m_run = 0; m_miss = 0; m_err = 0;
    m_vd = '0; m_cd = '0; m_vde = 1'b0;
  endtask

  task automatic model_step(input logic [9:0] w);
    logic [9:0] q_out;
    logic [9:0] q_new;
    bit         tok;
    int         code;
    q_out = m_pend;
    q_new = ref_slice(m_p1, m_p2, m_off);
    m_p2  = m_p1;
    m_p1  = w;
    tok   = 1'b0;
    code  = 0;
    for (int i = 0; i < 4; i++) begin
      if (q_out == tok_word(i)) begin
        tok  = 1'b1;
        code = i;
      end
    end
    m_run = tok ? m_run + 1 : 0;
    if (m_run >= LOCK_TOKENS) begin
      m_locked = 1'b1;
      m_miss   = 0;
    end else if (m_miss == SLIP_WORDS - 1) begin
      if (m_locked) begin
        m_locked = 1'b0;
        if (m_err < 65535) m_err++;
      end else begin
        m_off = (m_off + 1) % 10;
      end
      m_run  = 0;
      m_miss = 0;
    end else begin
      m_miss++;
    end
    if (m_locked) begin
      if (tok) begin
        m_vde = 1'b0;
        m_cd  = 2'(code);
      end else begin
        m_vde = 1'b1;
        m_vd  = ref_decode(q_out);
      end
    end else begin
      m_vd = '0; m_cd = '0; m_vde = 1'b0;
    end
    m_pend = q_new;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h (valid edge %0d)", tag, obs, exp, vedge);
    end
  endtask

  task automatic check_all(input logic v);
    check("dout_valid",   32'(dout_valid),   32'(v));
    check("locked",       32'(locked),       32'(m_locked));
    check("align_offset", 32'(align_offset), 32'(m_off));
    check("vd",           32'(vd),           32'(m_vd));
    check("cd",           32'(cd),           32'(m_cd));
    check("vde",          32'(vde),          32'(m_vde));
    check("err_count",    32'(err_count),    ERRCNT ? 32'(m_err) : 32'd0);
  endtask

  task automatic send(input logic [9:0] w, input logic v);
    din       = w;
    din_valid = v;
    @(posedge clk);
    #1;
    if (v) begin
      vedge++;
      model_step(w);
    end
    check_all(v);
  endtask

  function automatic logic [9:0] rand_word();
    if ($urandom_range(0, 3) == 0) return tok_word(int'($urandom_range(0, 3)));
    return enc_word(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
  endfunction

  initial begin
    // Power-on reset
    rst = 1'b1; din = '0; din_valid = 1'b0;
    model_reset();
    vedge = 0;
    repeat (3) @(posedge clk);
    #1;
    check_all(1'b0);
    rst = 1'b0;
    send(10'h3FF, 1'b0);

    // Aligned lock at offset 0: 8th token is output on valid edge 11
    for (int i = 1; i <= 11; i++) begin
      send(tok_word(0), 1'b1);
      if (i == 10) check("lock_not_yet", 32'(locked), 32'd0);
      if (i == 11) begin
        check("lock_edge",  32'(locked), 32'd1);
        check("lock_cd",    32'(cd),     32'd0);
        check("lock_vde",   32'(vde),    32'd0);
      end
    end

    // Data decode after lock, both inversion branches; cd held at 11
    blist[0] = 8'h00; blist[1] = 8'hFF; blist[2] = 8'h55; blist[3] = 8'hA7;
    for (int i = 0; i < 14; i++) begin
      dw[i] = tok_word(3); db[i] = 8'h00; dd[i] = 1'b0;
    end
    for (int i = 0; i < 8; i++) begin
      db[3+i] = blist[i/2];
      dw[3+i] = enc_word(blist[i/2], 1'(i % 2));
      dd[3+i] = 1'b1;
    end
    for (int s = 0; s < 14; s++) begin
      send(dw[s], 1'b1);
      if (s >= 3 && dd[s-3]) begin
        check("data_vd",  32'(vd),  32'(db[s-3]));
        check("data_vde", 32'(vde), 32'd1);
        check("data_cd",  32'(cd),  32'd3);
      end
    end

    // Random mix of tokens and data while locked
    for (int i = 0; i < 200; i++) send(rand_word(), 1'b1);
    for (int i = 0; i < 10; i++) send(tok_word(int'($urandom_range(0, 3))), 1'b1);

    // din_valid every third cycle
    for (int i = 0; i < 60; i++) begin
      send(10'($urandom), 1'b0);
      send(10'($urandom), 1'b0);
      send(rand_word(), 1'b1);
    end
    for (int i = 0; i < 10; i++) send(tok_word(1), 1'b1);

    // Loss of lock: the 1024th data word reaches the output on send 1027
    fall = 0;
    for (int j = 1; j <= 1030; j++) begin
      send(enc_word(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1))), 1'b1);
      if (fall == 0 && locked == 1'b0) fall = j;
    end
    check("loss_edge",   32'(fall),         32'd1027);
    check("loss_offset", 32'(align_offset), 32'd0);
    check("loss_errcnt", 32'(err_count),    ERRCNT ? 32'd1 : 32'd0);

    // Relock, then asynchronous reset mid-cycle
    for (int i = 0; i < 20; i++) send(tok_word(2), 1'b1);
    check("relock", 32'(locked), 32'd1);
    din_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    vedge = 0;
    check_all(1'b0);
    @(posedge clk);
    #1;
    check_all(1'b0);
    rst = 1'b0;
    send(10'h000, 1'b0);
    check("post_rst_locked", 32'(locked),       32'd0);
    check("post_rst_offset", 32'(align_offset), 32'd0);

    // Phase hunt: stream delayed by 3 bits
    prev_cd = 2'd0;
    for (int n = 1; n <= 3086; n++) begin
      send(stream_word(n), 1'b1);
      if (n == 1023) check("hunt_off0", 32'(align_offset), 32'd0);
      if (n == 1024) check("hunt_off1", 32'(align_offset), 32'd1);
      if (n == 2048) check("hunt_off2", 32'(align_offset), 32'd2);
      if (n == 3072) check("hunt_off3", 32'(align_offset), 32'd3);
      if (n == 3080) check("hunt_nolock", 32'(locked), 32'd0);
      if (n == 3081) check("hunt_lock",   32'(locked), 32'd1);
      if (n > 3081)  check("hunt_cd_seq", 32'(cd), 32'(2'(prev_cd + 2'd1)));
      prev_cd = cd;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
